// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision constants,
// converter FSM state type and operand-kind encoding.
package fp_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // exponent landmarks: 0.5, 1.0, binary point at lsb, 2^31
  localparam logic [EXP_W-1:0] E_HALF = EXP_W'(EXP_BIAS - 1);
  localparam logic [EXP_W-1:0] E_ONE  = EXP_W'(EXP_BIAS);
  localparam logic [EXP_W-1:0] E_PT   = EXP_W'(EXP_BIAS + FRAC_W);
  localparam logic [EXP_W-1:0] E_SAT  = EXP_W'(EXP_BIAS + 31);

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_SHIFT  = 2'd1;
  localparam state_t S_FINISH = 2'd2;

  typedef enum logic [1:0] {
    K_ZERO,
    K_NORM,
    K_SAT,
    K_MIN
  } kind_t;

  typedef logic [4:0] cnt_t;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: combinational fp32 field split and class flags.
// Ports: a (operand) -> sign, expo, frac, is_zero/denorm/normal/inf/nan.
module fp32_classify
  import fp_pkg::*;
(
  input  logic [31:0]       a,
  output logic              sign,
  output logic [EXP_W-1:0]  expo,
  output logic [FRAC_W-1:0] frac,
  output logic              is_zero,
  output logic              is_denorm,
  output logic              is_normal,
  output logic              is_inf,
  output logic              is_nan
);
  logic e_min;
  logic e_max;
  logic f_zero;

  assign sign   = a[31];
  assign expo   = a[30:23];
  assign frac   = a[22:0];
  assign e_min  = ~|expo;
  assign e_max  = &expo;
  assign f_zero = ~|frac;

  assign is_zero   = e_min & f_zero;
  assign is_denorm = e_min & ~f_zero;
  assign is_normal = ~e_min & ~e_max;
  assign is_inf    = e_max & f_zero;
  assign is_nan    = e_max & ~f_zero;
endmodule

// File: rtl/fp32_to_int32.sv
// fp32_to_int32: multi-cycle fp32 -> int32 converter, one shift per cycle.
// Ports: clk, rst (async low), en, load, A -> result, ready, busy, overflow.
// Macro FP2INT_ROUND_EN: round-nearest-even, else truncate toward zero.
module fp32_to_int32
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] A,
  output logic [31:0] result,
  output logic        ready,
  output logic        busy,
  output logic        overflow
);
`ifdef FP2INT_ROUND_EN
  // integer part plus guard and sticky bits
  localparam int MW = 34;
`else
  localparam int MW = 32;
`endif

  state_t  state;
  cnt_t    cnt;
  kind_t   kind;
  logic    sgn;
  logic    lft;
  logic [MW-1:0] mant;

  logic              c_sgn;
  logic [EXP_W-1:0]  ex;
  logic [FRAC_W-1:0] fr;
  logic c_zero, c_den, c_norm, c_inf, c_nan;

  fp32_classify u_cls (
    .a         (A),
    .sign      (c_sgn),
    .expo      (ex),
    .frac      (fr),
    .is_zero   (c_zero),
    .is_denorm (c_den),
    .is_normal (c_norm),
    .is_inf    (c_inf),
    .is_nan    (c_nan)
  );

  kind_t   k_n;
  cnt_t    n_n;
  logic    s_n;
  logic    l_n;
  logic [MW-1:0] m_n;

  always_comb begin
    k_n = K_ZERO;
    n_n = '0;
    s_n = c_sgn;
    l_n = 1'b0;
`ifdef FP2INT_ROUND_EN
    m_n = {8'b0, 1'b1, fr, 2'b00};
`else
    m_n = {8'b0, 1'b1, fr};
`endif
    unique case (1'b1)
      c_nan: begin
        k_n = K_SAT;
        s_n = 1'b0;
      end
      c_inf: k_n = K_SAT;
      c_zero | c_den: k_n = K_ZERO;
      c_norm && ex >= E_SAT: begin
        // -2^31 is exactly representable
        k_n = (c_sgn && ex == E_SAT && fr == '0)
            ? K_MIN : K_SAT;
      end
      c_norm && ex >= E_ONE && ex < E_SAT: begin
        k_n = K_NORM;
        l_n = ex > E_PT;
        n_n = (ex > E_PT) ? cnt_t'(ex - E_PT)
                          : cnt_t'(E_PT - ex);
      end
`ifdef FP2INT_ROUND_EN
      c_norm && ex == E_HALF: begin
        // value in [0.5,1): all weight in guard/sticky
        k_n = K_NORM;
        m_n = {32'b0, 1'b1, |fr};
      end
`endif
      default: k_n = K_ZERO;
    endcase
  end

  logic [MW-1:0] shr;
`ifdef FP2INT_ROUND_EN
  assign shr = {1'b0, mant[MW-1:2], mant[1] | mant[0]};
`else
  assign shr = {1'b0, mant[MW-1:1]};
`endif

  logic [31:0] mag;
  logic [32:0] mag_r;
  logic        big;
  logic [31:0] res_n;
  logic        ovf_n;

  assign mag = mant[MW-1 -: 32];

`ifdef FP2INT_ROUND_EN
  logic rup;
  assign rup   = mant[1] & (mant[0] | mant[2]);
  assign mag_r = {1'b0, mag} + {32'b0, rup};
`else
  assign mag_r = {1'b0, mag};
`endif

  // beyond +2^31-1, or beyond 2^31 in magnitude when negative
  assign big = mag_r[32]
             | (mag_r[31] & (~sgn | (|mag_r[30:0])));

  always_comb begin
    res_n = '0;
    ovf_n = 1'b0;
    unique case (kind)
      K_MIN: res_n = INT_MIN;
      K_SAT: begin
        res_n = sgn ? INT_MIN : INT_MAX;
        ovf_n = 1'b1;
      end
      K_NORM: begin
        if (big) begin
          res_n = sgn ? INT_MIN : INT_MAX;
          ovf_n = 1'b1;
        end else begin
          res_n = sgn ? (~mag_r[31:0] + 32'd1)
                      : mag_r[31:0];
        end
      end
      default: res_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      kind     <= K_ZERO;
      sgn      <= 1'b0;
      lft      <= 1'b0;
      mant     <= '0;
      result   <= '0;
      ready    <= 1'b0;
      overflow <= 1'b0;
    end else if (en) begin
      unique case (state)
        S_IDLE: begin
          if (load) begin
            state <= S_SHIFT;
            cnt   <= n_n;
            kind  <= k_n;
            sgn   <= s_n;
            lft   <= l_n;
            mant  <= m_n;
            ready <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (cnt == '0) begin
            state <= S_FINISH;
          end else begin
            cnt  <= cnt - cnt_t'(1);
            mant <= lft ? (mant << 1) : shr;
          end
        end
        S_FINISH: begin
          state    <= S_IDLE;
          result   <= res_n;
          overflow <= ovf_n;
          ready    <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_SHIFT) | (state == S_FINISH);
endmodule

// File: tb/tb_fp32_to_int32.sv
// tb_fp32_to_int32: randomized and directed checks of fp32_to_int32
// against an arithmetic reference model.
module tb_fp32_to_int32;
`ifdef FP2INT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [31:0] A;
  logic [31:0] result;
  logic        ready;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp32_to_int32 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .A        (A),
    .result   (result),
    .ready    (ready),
    .busy     (busy),
    .overflow (overflow)
  );

  // value = {1,frac} * 2^(e-150); latency = shift count + 2
  function automatic void model(input logic [31:0] a,
                                output logic [31:0] r,
                                output logic o,
                                output int lat);
    int     e;
    int     sh;
    bit     s;
    longint m;
    longint mag;
    longint rem;
    longint half;
    longint sval;
    e   = int'(a[30:23]);
    s   = a[31];
    m   = longint'({1'b1, a[22:0]});
    r   = 32'h0;
    o   = 1'b0;
    lat = 2;
    if (e == 255) begin
      o = 1'b1;
      r = (a[22:0] != 0 || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return;
    end
    if (e == 0) return;
    sh = e - 150;
    if (e >= 127 && e <= 157) lat = (sh < 0 ? -sh : sh) + 2;
    if (sh > 8) begin
      mag = 64'sd1 <<< 40;
    end else if (sh >= 0) begin
      mag = m <<< sh;
    end else if (-sh > 40) begin
      mag = 0;
    end else begin
      mag  = m >>> (-sh);
      rem  = m - (mag <<< (-sh));
      half = 64'sd1 <<< (-sh - 1);
      if (RND && (rem > half || (rem == half && (mag % 2) == 1)))
        mag = mag + 1;
    end
    sval = s ? -mag : mag;
    if (sval > 64'sd2147483647) begin
      r = 32'h7FFF_FFFF;
      o = 1'b1;
    end else if (sval < -64'sd2147483648) begin
      r = 32'h8000_0000;
      o = 1'b1;
    end else begin
      r = sval[31:0];
    end
  endfunction

  // starts #1 after a rising edge with the DUT idle
  task automatic run_conv(input logic [31:0] a,
                          output logic [31:0] r,
                          output logic o,
                          output int edges,
                          output bit acc_ok);
    A    = a;
    load = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
    acc_ok = (ready === 1'b0) && (busy === 1'b1);
    edges  = 0;
    while (ready !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    r = result;
    o = overflow;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b1;
    load = 1'b0;
    A    = 32'h0;
    #1 rst = 1'b0;
    #2;
    total++;
    if (result !== 32'h0) begin
      bad++;
      $display("FAIL reset_result got=%h want=0", result);
    end
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b want=0", ready);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%b want=0", overflow);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] da [16];
    logic [31:0] dr [16];
    logic        dov[16];
    int          dl [16];
    logic [31:0] r;
    logic        o;
    int          ed;
    bit          ac;
    da = '{32'h3F80_0000, 32'hC2F6_0000, 32'h4F00_0000, 32'hCF00_0000,
           32'h7FC0_0000, 32'h4020_0000, 32'h4060_0000, 32'h7F80_0000,
           32'hFF80_0000, 32'h0000_0000, 32'h8000_0001, 32'h3F40_0000,
           32'h3F00_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'hBFC0_0000};
    dr = '{32'h1, 32'hFFFF_FF85, 32'h7FFF_FFFF, 32'h8000_0000,
           32'h7FFF_FFFF, 32'h2, RND ? 32'h4 : 32'h3, 32'h7FFF_FFFF,
           32'h8000_0000, 32'h0, 32'h0, RND ? 32'h1 : 32'h0,
           32'h0, 32'h7FFF_FF80, 32'h8000_0080,
           RND ? 32'hFFFF_FFFE : 32'hFFFF_FFFF};
    dov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
            1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    dl = '{25, 19, 2, 2, 2, 24, 24, 2, 2, 2, 2, 2, 2, 9, 9, 25};
    for (int i = 0; i < 16; i++) begin
      run_conv(da[i], r, o, ed, ac);
      total++;
      if (r !== dr[i]) begin
        bad++;
        $display("FAIL dir_result a=%h got=%h want=%h", da[i], r, dr[i]);
      end
      total++;
      if (o !== dov[i]) begin
        bad++;
        $display("FAIL dir_ovf a=%h got=%b want=%b", da[i], o, dov[i]);
      end
      total++;
      if (ed != dl[i]) begin
        bad++;
        $display("FAIL dir_latency a=%h got=%0d want=%0d", da[i], ed, dl[i]);
      end
      total++;
      if (!ac) begin
        bad++;
        $display("FAIL dir_accept a=%h got=ready%b/busy%b want=0/1",
                 da[i], ready, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] r;
    logic [31:0] er;
    logic        o;
    logic        eo;
    int          ed;
    int          el;
    bit          ac;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if (i % 4 != 0) a[30:23] = 8'($urandom_range(120, 165));
      model(a, er, eo, el);
      run_conv(a, r, o, ed, ac);
      total++;
      if (r !== er || o !== eo || ed != el) begin
        bad++;
        $display("FAIL rand a=%h got=%h/%b/%0d want=%h/%b/%0d",
                 a, r, o, ed, er, eo, el);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic        o;
    int          ed;
    bit          ac;
    A    = 32'h3F80_0000;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy_before got=%b want=1", busy);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (result !== 32'h0 || ready !== 1'b0 ||
        busy !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs got=%h/%b/%b/%b want=0/0/0/0",
               result, ready, busy, overflow);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_conv(32'h4000_0000, r, o, ed, ac);
    total++;
    if (r !== 32'h2 || o !== 1'b0 || ed != 24) begin
      bad++;
      $display("FAIL midrst_reload got=%h/%b/%0d want=2/0/24", r, o, ed);
    end
  endtask

  task automatic test_en_stall();
    int ed;
    A    = 32'h3F80_0000;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    ed   = 0;
    repeat (5) begin
      @(posedge clk); #1;
      ed++;
    end
    en   = 1'b0;
    A    = 32'h4040_0000;
    load = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      ed++;
    end
    total++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_hold got=busy%b/ready%b want=1/0", busy, ready);
    end
    en = 1'b1;
    @(posedge clk); #1;
    ed++;
    load = 1'b0;
    while (ready !== 1'b1 && ed < 100) begin
      @(posedge clk); #1;
      ed++;
    end
    total++;
    if (ed != 30) begin
      bad++;
      $display("FAIL stall_latency got=%0d want=30", ed);
    end
    total++;
    if (result !== 32'h1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL stall_result got=%h/%b want=1/0", result, overflow);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || ready !== 1'b1 || result !== 32'h1) begin
      bad++;
      $display("FAIL busy_load_ignored got=%b/%b/%h want=0/1/1",
               busy, ready, result);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] r;
    logic [31:0] er;
    logic        o;
    logic        eo;
    int          ed;
    int          el;
    bit          ac;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      a[30:23] = 8'($urandom_range(124, 160));
      model(a, er, eo, el);
      run_conv(a, r, o, ed, ac);
      total++;
      if (r !== er || o !== eo || ed != el || !ac) begin
        bad++;
        $display("FAIL b2b a=%h got=%h/%b/%0d/%b want=%h/%b/%0d/1",
                 a, r, o, ed, ac, er, eo, el);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b1 || result !== er) begin
      bad++;
      $display("FAIL ready_held got=%b/%h want=1/%h", ready, result, er);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_en_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp32_to_int32.md
FP32_TO_INT32 -- requirements
Module: fp32_to_int32

Interface
REQ-001 SHALL: clk  input  1  rising-edge system clock.
REQ-002 SHALL: rst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL: en  input  1  clock enable; all state holds while en=0.
REQ-004 SHALL: load  input  1  start request, sampled in IDLE when en=1.
REQ-005 SHALL: A  input  32  IEEE-754 single-precision operand (sign A[31], exponent A[30:23], fraction A[22:0]).
REQ-006 SHALL: result  output  32  signed two's-complement integer result, registered.
REQ-007 SHALL: ready  output  1  high when result is valid; held until the next accepted load.
REQ-008 SHALL: busy  output  1  high in SHIFT and FINISH states.
REQ-009 SHALL: overflow  output  1  result saturated (out of range, Inf or NaN); valid with ready.

Function
REQ-010 SHALL implement the FSM IDLE -> SHIFT -> FINISH -> IDLE; load accepted only in IDLE with en=1, ignored otherwise.
REQ-011 SHALL, on acceptance, capture sign, exponent e and mantissa {1,fraction} with 2 extra guard/sticky bits, clear ready, and set count N.
REQ-012 SHALL set N = 150-e when 127<=e<=150 (right shift), N = e-150 when 150<e<=157 (left shift), otherwise N = 0.
REQ-013 SHALL shift the mantissa one bit per enabled cycle in SHIFT, decrementing count; the state moves to FINISH when count reaches 0.
REQ-014 SHALL, in FINISH, apply rounding (REQ-022/023), negate if the sign is set, register result, set ready, and return to IDLE.
REQ-015 SHALL assert ready N+2 enabled clock edges after the edge that accepted load.
REQ-016 SHALL return result 0, overflow 0 for zero, denormal, or e<126 (e=126 also 0 without rounding).
REQ-017 SHALL saturate when e>=158: result 0x7FFFFFFF (positive) or 0x80000000 (negative), overflow=1; exception: A=0xCF000000 gives 0x80000000 with overflow=0.
REQ-018 SHALL treat Inf as saturation by sign, and NaN as 0x7FFFFFFF, overflow=1.
REQ-019 SHALL saturate with overflow=1 when rounding carries the magnitude beyond the int32 range.
REQ-020 SHALL freeze state, count and outputs while en=0 at any point, and resume on the next enabled edge.

Reset
REQ-021 SHALL, on rst low at any time including mid-shift, force IDLE, result=0, ready=0, busy=0, overflow=0, and count=0 immediately.

Configuration
REQ-022 SHALL, with macro FP2INT_ROUND_EN defined, round to nearest, ties to even, using guard and sticky bits; e=126 may produce magnitude 1.
REQ-023 SHALL, without FP2INT_ROUND_EN, truncate toward zero; guard and sticky logic is absent.

Structure
REQ-024 SHALL take EXP_BIAS=127, EXP_W=8, FRAC_W=23, INT_MAX/INT_MIN constants and the FSM state type from shared package fp_pkg.
REQ-025 SHALL place operand classification (zero/denormal/normal/inf/nan) in one combinational sub-module fp32_classify, reusable by the adder path.

Verification
REQ-026 SHALL check: A=0x3F800000 (1.0) -> result 0x00000001, overflow 0, ready after 25 edges.
REQ-027 SHALL check: A=0xC2F60000 (-123.0) -> result 0xFFFFFF85, ready after 19 edges.
REQ-028 SHALL check: A=0x4F000000 -> 0x7FFFFFFF, overflow 1; A=0xCF000000 -> 0x80000000, overflow 0; A=0x7FC00000 (NaN) -> 0x7FFFFFFF, overflow 1, ready after 2 edges.
REQ-029 SHALL check: A=0x40200000 (2.5) -> 2 in both builds; A=0x40600000 (3.5) -> 3 without FP2INT_ROUND_EN, 4 with it.
REQ-030 SHALL check: rst low during SHIFT of 1.0 -> all outputs 0 immediately; a new load of 0x40000000 after release -> result 2.
REQ-031 SHALL check: en held low for 5 cycles mid-shift -> ready delayed by exactly 5 cycles, result unchanged; load pulsed while busy -> ignored.
